uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The module SHALL have parameter CLK_FREQ, default 25_600_000: system clock frequency in Hz.
REQ-002 The module SHALL have parameter UART_BPS, default 115200: baud rate; BPS_CNT = CLK_FREQ / UART_BPS (integer division), which SHALL be at least 4.
REQ-003 The module SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-004 The module SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 The module SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-006 The module SHALL have parameter FIFO_DEPTH, default 16: transmit buffer entries, a power of 2 and at least 2; AW = clog2(FIFO_DEPTH).
REQ-007 The module SHALL have port sys_clk, input, 1 bit: clock.
REQ-008 The module SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The module SHALL have port tx_valid, input, 1 bit: write request.
REQ-010 The module SHALL have port tx_data, input, DATA_BITS bits: word to transmit, sent LSB first.
REQ-011 The module SHALL have port tx_ready, output, 1 bit: buffer can accept a word.
REQ-012 The module SHALL have port fifo_level, output, AW+1 bits: number of words buffered.
REQ-013 The module SHALL have port uart_tx_busy, output, 1 bit: a frame is in progress.
REQ-014 The module SHALL have port uart_txd, output, 1 bit: serial line, idle high.

Function
REQ-015 A word SHALL be accepted on a rising sys_clk edge where tx_valid and tx_ready are both high; tx_valid with tx_ready low SHALL be ignored (no data loss inside the block).
REQ-016 tx_ready SHALL equal (fifo_level != FIFO_DEPTH); there SHALL be no bypass path around the buffer.
REQ-017 fifo_level SHALL increment on a push only, decrement on a pop only, and stay unchanged on a simultaneous push and pop; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PAR, STOP; a baud counter SHALL count 0..BPS_CNT-1, with each bit period exactly BPS_CNT clocks.
REQ-019 In IDLE with fifo_level != 0, the FSM SHALL pop the head word into a shift register and enter START on the same edge.
REQ-020 START SHALL drive 0 for one bit period, then enter DATA.
REQ-021 DATA SHALL drive DATA_BITS bits, LSB first, then enter PAR if PARITY != 0, otherwise STOP.
REQ-022 PAR SHALL drive XOR of the data bits for even parity and its inverse for odd parity.
REQ-023 STOP SHALL drive 1 for STOP_BITS bit periods.
REQ-024 At the end of STOP with fifo_level != 0, the FSM SHALL pop and enter START directly, with no idle gap; otherwise it SHALL enter IDLE.
REQ-025 uart_txd SHALL be registered and SHALL be 1 in IDLE.
REQ-026 A word pushed at edge E into an empty buffer while IDLE SHALL produce uart_txd = 0 from edge E+2.
REQ-027 uart_tx_busy SHALL be high in every state other than IDLE.
REQ-028 Frame length SHALL be (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BPS_CNT clocks.
REQ-029 A buffered word SHALL be transmitted unaltered even if tx_data changes afterward.
REQ-030 Parameter values outside their legal ranges SHALL be unsupported; no runtime checking is required.

Reset
REQ-031 Assertion of sys_rst_n low SHALL, asynchronously and including mid-frame, force uart_txd = 1, uart_tx_busy = 0, fifo_level = 0, tx_ready = 1, FSM = IDLE, clear all counters and pointers, and discard buffered words.
REQ-032 After reset deassertion, the first push SHALL obey REQ-026.

Verification (test parameters BPS_CNT = 16 unless stated)
REQ-033 Default parameters, push 0x55 -> uart_txd = 0 at E+2, then 1,0,1,0,1,0,1,0, then 1; frame = 160 clocks; busy high exactly 160 clocks.
REQ-034 DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, push 0x03 -> bits: start 0, data 1,1,0,0,0,0,0, parity 0, stop 1,1; frame = 176 clocks.
REQ-035 PARITY = 1, DATA_BITS = 8, push 0x00 -> parity bit 1.
REQ-036 FIFO_DEPTH = 4, hold tx_valid high for 8 words 0x01..0x08 -> tx_ready drops when fifo_level = 4; all 8 words are sent in order back-to-back, with every stop-bit end followed immediately by a start bit.
REQ-037 Push on the same edge as a pop with fifo_level = 2 -> fifo_level stays 2.
REQ-038 Assert reset during data bit 3 of 0xA5 with 2 words queued -> uart_txd = 1 and fifo_level = 0 immediately; after release, line idle and no residual frame transmitted.

Source files
------------

// File: rtl/uart_tx_param.sv
// Buffered UART transmitter: a FIFO feeds a start/data/parity/stop serializer.
// Frames are sent back-to-back while words are queued; the line idles high.
module uart_tx_param #(
  parameter int CLK_FREQ   = 25_600_000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          uart_tx_busy,
  output logic                          uart_txd
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int CW      = $clog2(BPS_CNT);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // Transmit buffer
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          level_reg, level_next;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (level_reg != (AW+1)'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign head       = mem[rd_ptr_reg];
  assign fifo_level = level_reg;

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr_reg] <= tx_data;
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + (AW+1)'(1);
      2'b01:   level_next = level_reg - (AW+1)'(1);
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      level_reg <= level_next;
    end
  end

  // Serializer
  state_t               state_reg, state_next;
  logic [CW-1:0]        baud_reg, baud_next;
  logic [2:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 txd_reg, txd_next;
  logic                 baud_end;

  assign baud_end     = (baud_reg == CW'(BPS_CNT - 1));
  assign uart_tx_busy = (state_reg != IDLE);
  assign uart_txd     = txd_reg;

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    pop        = 1'b0;
    txd_next   = 1'b1;
    if (state_reg != IDLE) baud_next = baud_end ? '0 : baud_reg + CW'(1);
    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        if (level_reg != '0) begin
          pop        = 1'b1;
          shift_next = head;
          // Even parity is the XOR of the data; odd parity inverts it.
          par_next   = (^head) ^ (PARITY == 1);
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (baud_end) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        txd_next = shift_reg[0];
        if (baud_end) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == 3'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      PAR: begin
        txd_next = par_reg;
        if (baud_end) begin
          state_next = STOP;
          bit_next   = '0;
        end
      end
      STOP: begin
        txd_next = 1'b1;
        if (baud_end) begin
          if (bit_reg == 3'(STOP_BITS - 1)) begin
            bit_next = '0;
            // Chain straight into the next frame when a word is waiting.
            if (level_reg != '0) begin
              pop        = 1'b1;
              shift_next = head;
              par_next   = (^head) ^ (PARITY == 1);
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      txd_reg   <= txd_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: three instances (8N1, 7E2, 8O1 with a 4-deep buffer)
// running at 16 clocks per bit.
module tb_uart_tx_param;

  localparam int CLK_FREQ = 1_843_200;
  localparam int BPS      = 115200;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       valid_a, ready_a, busy_a, txd_a;
  logic [7:0] data_a;
  logic [4:0] level_a;
  logic       valid_b, ready_b, busy_b, txd_b;
  logic [6:0] data_b;
  logic [4:0] level_b;
  logic       valid_c, ready_c, busy_c, txd_c;
  logic [7:0] data_c;
  logic [2:0] level_c;

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS)) u_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .fifo_level(level_a), .uart_tx_busy(busy_a), .uart_txd(txd_a)
  );

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .DATA_BITS(7), .PARITY(2),
                  .STOP_BITS(2)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .fifo_level(level_b), .uart_tx_busy(busy_b), .uart_txd(txd_b)
  );

  uart_tx_param #(.CLK_FREQ(CLK_FREQ), .UART_BPS(BPS), .PARITY(1), .FIFO_DEPTH(4)) u_c (
    .sys_clk(clk), .sys_rst_n(rst_n), .tx_valid(valid_c), .tx_data(data_c),
    .tx_ready(ready_c), .fifo_level(level_c), .uart_tx_busy(busy_c), .uart_txd(txd_c)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected line bits, index 0 = start bit, idle-high fill beyond the stop bits.
  function automatic logic [15:0] make_frame(input logic [7:0] d, input int nbits, input int par);
    logic [15:0] f;
    logic        p;
    int          n;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    n    = 1;
    for (int i = 0; i < nbits; i++) begin
      f[n] = d[i];
      p    = p ^ d[i];
      n++;
    end
    if (par != 0) f[n] = (par == 1) ? ~p : p;
    return f;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 5'd0 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: txd=%b busy=%b level=%0d ready=%b, required 1 0 0 1",
               txd_a, busy_a, level_a, ready_a);
    end
    checks++;
    if (txd_b !== 1'b1 || busy_b !== 1'b0 || level_b !== 5'd0 || ready_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_b: txd=%b busy=%b level=%0d ready=%b, required 1 0 0 1",
               txd_b, busy_b, level_b, ready_b);
    end
    checks++;
    if (txd_c !== 1'b1 || busy_c !== 1'b0 || level_c !== 3'd0 || ready_c !== 1'b1) begin
      errors++;
      $display("FAIL reset_c: txd=%b busy=%b level=%0d ready=%b, required 1 0 0 1",
               txd_c, busy_c, level_c, ready_c);
    end
    tick;
    #2 rst_n = 1'b1;
    tick;
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: txd=%b busy=%b level=%0d, required 1 0 0", txd_a, busy_a, level_a);
    end
    $display("test_reset done");
  endtask

  task automatic test_frame_8n1;
    logic [9:0] f;
    int busy_cnt;
    f = 10'b1010101010;
    data_a = 8'h55; valid_a = 1'b1;
    tick;
    valid_a = 1'b0; data_a = 8'hFF;
    checks++;
    if (level_a !== 5'd1 || busy_a !== 1'b0 || txd_a !== 1'b1) begin
      errors++;
      $display("FAIL 8n1_push: level=%0d busy=%b txd=%b, required 1 0 1", level_a, busy_a, txd_a);
    end
    busy_cnt = 0;
    for (int k = 0; k < 170; k++) begin
      tick;
      if (busy_a) busy_cnt++;
      if (k == 0) begin
        checks++;
        if (txd_a !== 1'b1) begin
          errors++;
          $display("FAIL 8n1_e1: txd=%b, required 1", txd_a);
        end
      end else if (k <= 160) begin
        checks++;
        if (txd_a !== f[(k-1)/16]) begin
          errors++;
          $display("FAIL 8n1_bit clk %0d: txd=%b, required %b", k - 1, txd_a, f[(k-1)/16]);
        end
      end
    end
    checks++;
    if (busy_cnt != 160) begin
      errors++;
      $display("FAIL 8n1_busy_len: busy clocks=%0d, required 160", busy_cnt);
    end
    checks++;
    if (busy_a !== 1'b0 || txd_a !== 1'b1 || level_a !== 5'd0) begin
      errors++;
      $display("FAIL 8n1_end: busy=%b txd=%b level=%0d, required 0 1 0", busy_a, txd_a, level_a);
    end
    $display("test_frame_8n1 0x55 done, busy clocks %0d", busy_cnt);
  endtask

  task automatic test_frame_7e2;
    logic [10:0] f;
    int busy_cnt;
    f = 11'b11000000110;
    data_b = 7'h03; valid_b = 1'b1;
    tick;
    valid_b = 1'b0; data_b = 7'h7F;
    busy_cnt = 0;
    for (int k = 0; k < 186; k++) begin
      tick;
      if (busy_b) busy_cnt++;
      if (k >= 1 && k <= 176) begin
        checks++;
        if (txd_b !== f[(k-1)/16]) begin
          errors++;
          $display("FAIL 7e2_bit clk %0d: txd=%b, required %b", k - 1, txd_b, f[(k-1)/16]);
        end
      end
    end
    checks++;
    if (busy_cnt != 176) begin
      errors++;
      $display("FAIL 7e2_busy_len: busy clocks=%0d, required 176", busy_cnt);
    end
    $display("test_frame_7e2 0x03 done, busy clocks %0d", busy_cnt);
  endtask

  task automatic test_odd_parity;
    logic [10:0] f;
    f = 11'b11000000000;
    data_c = 8'h00; valid_c = 1'b1;
    tick;
    valid_c = 1'b0; data_c = 8'hFF;
    for (int k = 0; k < 186; k++) begin
      tick;
      if (k >= 1 && k <= 176) begin
        checks++;
        if (txd_c !== f[(k-1)/16]) begin
          errors++;
          $display("FAIL odd_par_bit clk %0d: txd=%b, required %b", k - 1, txd_c, f[(k-1)/16]);
        end
      end
    end
    checks++;
    if (busy_c !== 1'b0) begin
      errors++;
      $display("FAIL odd_par_end: busy=%b, required 0", busy_c);
    end
    $display("test_odd_parity 0x00 done");
  endtask

  task automatic test_fifo_full_b2b;
    logic [15:0] fr [8];
    for (int i = 0; i < 8; i++) fr[i] = make_frame(8'(i + 1), 8, 1);
    fork
      begin
        int n;
        int guard;
        logic acc;
        logic saw_full;
        n = 0; guard = 0; saw_full = 1'b0;
        valid_c = 1'b1; data_c = 8'h01;
        while (n < 8 && guard < 3000) begin
          checks++;
          if (ready_c !== (level_c != 3'd4)) begin
            errors++;
            $display("FAIL b2b_ready: ready=%b level=%0d, required ready=%b",
                     ready_c, level_c, level_c != 3'd4);
          end
          if (level_c == 3'd4) saw_full = 1'b1;
          acc = ready_c;
          tick;
          if (acc) n++;
          if (n < 8) data_c = 8'(n + 1);
          else valid_c = 1'b0;
          guard++;
        end
        valid_c = 1'b0;
        checks++;
        if (n != 8) begin
          errors++;
          $display("FAIL b2b_push_timeout: accepted=%0d, required 8", n);
        end
        checks++;
        if (!saw_full) begin
          errors++;
          $display("FAIL b2b_full: level never reached 4, required 4");
        end
      end
      begin
        tick;
        tick;
        checks++;
        if (busy_c !== 1'b1 || txd_c !== 1'b1) begin
          errors++;
          $display("FAIL b2b_first: busy=%b txd=%b, required 1 1", busy_c, txd_c);
        end
        for (int j = 0; j < 8 * 176; j++) begin
          tick;
          checks++;
          if (txd_c !== fr[j/176][(j%176)/16]) begin
            errors++;
            $display("FAIL b2b_bit frame %0d clk %0d: txd=%b, required %b",
                     j / 176, j % 176, txd_c, fr[j/176][(j%176)/16]);
          end
          if (j < 8 * 176 - 1) begin
            checks++;
            if (busy_c !== 1'b1) begin
              errors++;
              $display("FAIL b2b_busy clk %0d: busy=%b, required 1", j, busy_c);
            end
          end
        end
        checks++;
        if (busy_c !== 1'b0 || level_c !== 3'd0 || txd_c !== 1'b1) begin
          errors++;
          $display("FAIL b2b_end: busy=%b level=%0d txd=%b, required 0 0 1", busy_c, level_c, txd_c);
        end
      end
    join
    $display("test_fifo_full_b2b words 0x01..0x08 done");
  endtask

  task automatic test_push_pop_same_edge;
    int g;
    valid_a = 1'b1; data_a = 8'h11;
    tick;
    data_a = 8'h22;
    tick;
    data_a = 8'h33;
    tick;
    valid_a = 1'b0;
    checks++;
    if (level_a !== 5'd2) begin
      errors++;
      $display("FAIL pp_level_pre: level=%0d, required 2", level_a);
    end
    repeat (158) tick;
    checks++;
    if (level_a !== 5'd2 || busy_a !== 1'b1 || txd_a !== 1'b1) begin
      errors++;
      $display("FAIL pp_before_pop: level=%0d busy=%b txd=%b, required 2 1 1", level_a, busy_a, txd_a);
    end
    valid_a = 1'b1; data_a = 8'h44;
    tick;
    valid_a = 1'b0;
    checks++;
    if (level_a !== 5'd2 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL pp_same_edge: level=%0d busy=%b, required 2 1", level_a, busy_a);
    end
    tick;
    checks++;
    if (txd_a !== 1'b0) begin
      errors++;
      $display("FAIL pp_no_gap: txd=%b, required 0", txd_a);
    end
    g = 0;
    while ((busy_a || level_a != 5'd0) && g < 800) begin
      tick;
      g++;
    end
    checks++;
    if (busy_a !== 1'b0 || level_a !== 5'd0) begin
      errors++;
      $display("FAIL pp_drain_timeout: busy=%b level=%0d, required 0 0", busy_a, level_a);
    end
    $display("test_push_pop_same_edge done, drained in %0d clocks", g);
  endtask

  task automatic test_reset_midframe;
    valid_a = 1'b1; data_a = 8'hA5;
    tick;
    data_a = 8'h3C;
    tick;
    data_a = 8'hC3;
    tick;
    valid_a = 1'b0;
    checks++;
    if (level_a !== 5'd2) begin
      errors++;
      $display("FAIL rst_queued: level=%0d, required 2", level_a);
    end
    repeat (70) tick;
    checks++;
    if (txd_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_bit3: txd=%b busy=%b, required 0 1", txd_a, busy_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (txd_a !== 1'b1 || level_a !== 5'd0 || busy_a !== 1'b0 || ready_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_async: txd=%b level=%0d busy=%b ready=%b, required 1 0 0 1",
               txd_a, level_a, busy_a, ready_a);
    end
    tick;
    tick;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 400; k++) begin
      tick;
      checks++;
      if (txd_a !== 1'b1 || busy_a !== 1'b0 || level_a !== 5'd0) begin
        errors++;
        $display("FAIL rst_residual clk %0d: txd=%b busy=%b level=%0d, required 1 0 0",
                 k, txd_a, busy_a, level_a);
      end
    end
    data_a = 8'h5A; valid_a = 1'b1;
    tick;
    valid_a = 1'b0;
    tick;
    checks++;
    if (txd_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_repush_e1: txd=%b busy=%b, required 1 1", txd_a, busy_a);
    end
    tick;
    checks++;
    if (txd_a !== 1'b0) begin
      errors++;
      $display("FAIL rst_repush_e2: txd=%b, required 0", txd_a);
    end
    repeat (170) tick;
    checks++;
    if (busy_a !== 1'b0 || txd_a !== 1'b1) begin
      errors++;
      $display("FAIL rst_repush_end: busy=%b txd=%b, required 0 1", busy_a, txd_a);
    end
    $display("test_reset_midframe 0xA5 done");
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_a = 1'b0; data_a = '0;
    valid_b = 1'b0; data_b = '0;
    valid_c = 1'b0; data_c = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick;
    test_reset;
    test_frame_8n1;
    test_frame_7e2;
    test_odd_parity;
    test_fifo_full_b2b;
    test_push_pop_same_edge;
    test_reset_midframe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
